// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles, branch
// squashes, data-memory wait freezes and a watchdog that locks on a stuck memory.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       ID_ReadRegNum1,
    input  logic [4:0]       ID_ReadRegNum2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             EX_cntl_MemRead,
    input  logic [4:0]       EX_WriteRegNum,
    input  logic             EX_BranchTaken,
    input  logic             MEM_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IF_IDWrite,
    output logic             IF_IDFlush,
    output logic             ID_EXWrite,
    output logic             ID_EXFlush,
    output logic             EX_MEMWrite,
    output logic             MEM_WBFlush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    state_t            r_state, w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_next;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_memstall;
    logic w_loaduse;
    logic w_freeze;
    logic w_squash;
    logic w_bubble;
    logic w_error;

    assign w_memstall = MEM_req & ~dmem_ready;
    assign w_loaduse  = EX_cntl_MemRead && (EX_WriteRegNum != 5'd0) &&
                        ((ID_uses_rs1 && (ID_ReadRegNum1 == EX_WriteRegNum)) ||
                         (ID_uses_rs2 && (ID_ReadRegNum2 == EX_WriteRegNum)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    // Hazard classification: at most one of freeze/squash/bubble/error is set.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        w_freeze     = 1'b0;
        w_squash     = 1'b0;
        w_bubble     = 1'b0;
        w_error      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_memstall) begin
                    w_freeze     = 1'b1;
                    w_state_next = ST_MEM_WAIT;
                    w_wait_next  = WAIT_W'(1);
                end else if (EX_BranchTaken) begin
                    w_squash = 1'b1;
                end else if (w_loaduse) begin
                    w_bubble = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_ready) begin
                    w_freeze = 1'b1;
                    if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        w_state_next = ST_ERROR;
                    end else begin
                        w_wait_next = r_wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    w_state_next = ST_RUN;
                    w_wait_next  = '0;
                    if (EX_BranchTaken) begin
                        w_squash = 1'b1;
                    end else if (w_loaduse) begin
                        w_bubble = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                w_error = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
                w_wait_next  = '0;
            end
        endcase
    end

    always_comb begin
        PCWrite     = 1'b1;
        IF_IDWrite  = 1'b1;
        IF_IDFlush  = 1'b0;
        ID_EXWrite  = 1'b1;
        ID_EXFlush  = 1'b0;
        EX_MEMWrite = 1'b1;
        MEM_WBFlush = 1'b0;
        mem_timeout = 1'b0;
        if (!reset_n) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            IF_IDFlush  = 1'b1;
            ID_EXWrite  = 1'b0;
            ID_EXFlush  = 1'b1;
            EX_MEMWrite = 1'b0;
            MEM_WBFlush = 1'b1;
        end else if (w_freeze || w_error) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXWrite  = 1'b0;
            EX_MEMWrite = 1'b0;
            MEM_WBFlush = 1'b1;
            mem_timeout = w_error;
        end else if (w_squash) begin
            IF_IDFlush = 1'b1;
            ID_EXFlush = 1'b1;
        end else if (w_bubble) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            ID_EXFlush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (!PCWrite && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
